// File: rtl/bk_accum_pkg.sv
// Shared types and constants for the burst accumulator and its Brent-Kung adder.
package bk_accum_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int LVL    = $clog2(DATA_W);

  typedef enum logic [0:0] {
    ST_ACC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bk_burst_accum_if.sv
// Operand stream and result stream of the burst accumulator, bundled as one interface.
interface bk_burst_accum_if #(
  parameter int CARRY_W = 8,
  parameter int CNT_W   = 8
);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [bk_accum_pkg::DATA_W-1:0]       in_data;
  logic                                  in_last;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [CARRY_W+bk_accum_pkg::DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]                      out_count;
  logic                                  out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/BKadder.sv
// 16-bit Brent-Kung parallel-prefix adder (carry-in fixed at zero).
module BKadder
  import bk_accum_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] gg;
  logic [DATA_W-1:0] pp;

  // Prefix (G,P) nodes are refined in place: the up-sweep builds power-of-two
  // spans, the down-sweep fills in the remaining prefixes from bit 0.
  always_comb begin
    p  = a ^ b;
    gg = a & b;
    pp = p;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          gg[IDX_W'(i)] = gg[IDX_W'(i)] | (pp[IDX_W'(i)] & gg[IDX_W'(i - (1 << l))]);
          pp[IDX_W'(i)] = pp[IDX_W'(i)] & pp[IDX_W'(i - (1 << l))];
        end
      end
    end
    for (int l = LVL - 2; l >= 0; l--) begin
      for (int i = 0; i < DATA_W; i++) begin
        if ((i >= (3 << l) - 1) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
          gg[IDX_W'(i)] = gg[IDX_W'(i)] | (pp[IDX_W'(i)] & gg[IDX_W'(i - (1 << l))]);
        end
      end
    end
    sum  = p ^ {gg[DATA_W-2:0], 1'b0};
    cout = gg[DATA_W-1];
  end

endmodule

// File: rtl/bk_burst_accum.sv
// Streaming burst accumulator around BKadder; widens the 16-bit sum with a carry counter.
// Optional feature macro BK_ACCUM_SAT_EN: saturate the total on carry overflow instead of wrapping.
module bk_burst_accum
  import bk_accum_pkg::*;
#(
  parameter int CARRY_W = 8,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst,
  bk_burst_accum_if.slave bus
);

  state_t              state;
  logic [DATA_W-1:0]   acc_lo;
  logic [CARRY_W-1:0]  carry_hi;
  logic [CNT_W-1:0]    count;
  logic                ovf;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [DATA_W-1:0]   sum;
  logic                cout;
  logic                ovf_hit;

  BKadder u_add (
    .a    (acc_lo),
    .b    (bus.in_data),
    .sum  (sum),
    .cout (cout)
  );

  assign ovf_hit = (&carry_hi) & cout;

  // NOTE: every register here is updated with <= so all reads in this block
  // see pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ACC;
      acc_lo      <= '0;
      carry_hi    <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.in_valid) begin
            count <= count + CNT_W'(1);
            ovf   <= ovf | ovf_hit;
`ifdef BK_ACCUM_SAT_EN
            // Once saturated, the total is pinned for the rest of the burst.
            if (ovf || ovf_hit) begin
              acc_lo   <= '1;
              carry_hi <= '1;
            end else begin
              acc_lo   <= sum;
              carry_hi <= carry_hi + CARRY_W'(cout);
            end
`else
            acc_lo   <= sum;
            carry_hi <= carry_hi + CARRY_W'(cout);
`endif
            if (bus.in_last) begin
              state       <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_ACC;
            acc_lo      <= '0;
            carry_hi    <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ST_ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = {carry_hi, acc_lo};
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_bk_burst_accum.sv
// Self-checking bench for bk_burst_accum: vector table, directed corner sequences, random bursts vs. a total-sum model.
module tb_bk_burst_accum;

  localparam int CARRY_W = 8;
  localparam int CNT_W   = 8;

  logic clk;
  logic rst;

  bk_burst_accum_if #(.CARRY_W(CARRY_W), .CNT_W(CNT_W)) bus ();

  bk_burst_accum #(.CARRY_W(CARRY_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int               n;
    logic [3:0][15:0] d;
    logic [23:0]      esum;
    int               ecnt;
    bit               eovf;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] bq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [23:0] esum, input int ecnt, input bit eovf);
    vec_t v;
    v.n    = n;
    v.d[0] = d0;
    v.d[1] = d1;
    v.d[2] = d2;
    v.d[3] = d3;
    v.esum = esum;
    v.ecnt = ecnt;
    v.eovf = eovf;
    return v;
  endfunction

  // Reference: the result is just the true sum of the burst, truncated or saturated to 24 bits.
  function automatic void model(output logic [23:0] s, output int c, output bit o);
    longint total = 0;
    foreach (bq[k]) total += longint'(bq[k]);
    o = (total >= 64'd16777216);
`ifdef BK_ACCUM_SAT_EN
    s = o ? 24'hFFFFFF : 24'(total);
`else
    s = 24'(total);
`endif
    c = bq.size() % 256;
  endfunction

  // Presents one beat; returns how many cycles in_ready was low before acceptance.
  task automatic push(input logic [15:0] d, input logic last, output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) check("push_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_burst(input bit gaps);
    int w;
    for (int k = 0; k < bq.size(); k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      push(bq[k], (k == bq.size() - 1), w);
    end
  endtask

  task automatic take(input string name, input logic [23:0] es, input int ec, input bit eo,
                      input int delay);
    int guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    check({name, "_sum"},   64'(bus.out_sum),   64'(es));
    check({name, "_count"}, 64'(bus.out_count), 64'(ec));
    check({name, "_ovf"},   64'(bus.out_ovf),   64'(eo));
    check({name, "_busy"},  64'(bus.in_ready),  64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, "_rdy"},   64'(bus.in_ready),  64'd1);
    check({name, "_vclr"},  64'(bus.out_valid), 64'd0);
    check({name, "_sclr"},  64'(bus.out_sum),   64'd0);
  endtask

  initial begin
    logic [23:0] es;
    int          ec;
    bit          eo;
    int          w;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);

    tbl[0] = mk(3, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 24'h000006, 3, 1'b0);
    tbl[1] = mk(2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 24'h010000, 2, 1'b0);
    tbl[2] = mk(1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 24'h000010, 1, 1'b0);
    tbl[3] = mk(3, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 24'h018000, 3, 1'b0);
    tbl[4] = mk(4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h03FFFC, 4, 1'b0);
    tbl[5] = mk(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 24'h000000, 1, 1'b0);

    foreach (tbl[v]) begin
      for (int k = 0; k < tbl[v].n; k++) push(tbl[v].d[k], (k == tbl[v].n - 1), w);
      check($sformatf("vec%0d_latency", v), 64'(bus.out_valid), 64'd1);
      take($sformatf("vec%0d", v), tbl[v].esum, tbl[v].ecnt, tbl[v].eovf, 0);
    end

    // Result held while the consumer stalls.
    push(16'h1234, 1'b1, w);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_sum",   64'(bus.out_sum),   64'h001234);
      check("hold_ready", 64'(bus.in_ready),  64'd0);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
    end
    take("hold", 24'h001234, 1, 1'b0, 0);

    // 257 x 0xFFFF: carry counter overflows, beat counter wraps to 1.
    for (int k = 0; k < 257; k++) push(16'hFFFF, (k == 256), w);
`ifdef BK_ACCUM_SAT_EN
    take("ovf257", 24'hFFFFFF, 1, 1'b1, 0);
`else
    take("ovf257", 24'h00FEFF, 1, 1'b1, 0);
`endif

    // Reset in the middle of a burst.
    push(16'h4000, 1'b0, w);
    push(16'h4000, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 64'(bus.in_ready),  64'd1);
    check("midrst_sum",   64'(bus.out_sum),   64'd0);
    check("midrst_count", 64'(bus.out_count), 64'd0);
    push(16'h0005, 1'b1, w);
    take("midrst", 24'h000005, 1, 1'b0, 0);

    // Reset while a result is waiting.
    push(16'h0077, 1'b1, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("donerst_valid", 64'(bus.out_valid), 64'd0);
    check("donerst_ready", 64'(bus.in_ready),  64'd1);
    check("donerst_sum",   64'(bus.out_sum),   64'd0);

    // Back-to-back bursts with the consumer always ready.
    bus.out_ready = 1'b1;
    push(16'h0010, 1'b1, w);
    check("b2b_valid0", 64'(bus.out_valid), 64'd1);
    check("b2b_sum0",   64'(bus.out_sum),   64'h000010);
    check("b2b_gap0",   64'(bus.in_ready),  64'd0);
    push(16'h0020, 1'b1, w);
    check("b2b_gap",    64'(w),             64'd1);
    check("b2b_valid1", 64'(bus.out_valid), 64'd1);
    check("b2b_sum1",   64'(bus.out_sum),   64'h000020);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_ready",  64'(bus.in_ready),  64'd1);

    // Random bursts, with idle gaps and consumer stalls.
    for (int b = 0; b < 25; b++) begin
      int len;
      len = (b == 12) ? 600 : int'($urandom_range(1, 12));
      bq.delete();
      for (int k = 0; k < len; k++) bq.push_back(16'($urandom));
      model(es, ec, eo);
      run_burst(1'b1);
      take($sformatf("rnd%0d", b), es, ec, eo, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
